// File: rtl/comparator_serial_bdeduffy_pkg.sv
// rtl/comparator_serial_bdeduffy_pkg.sv - shared FSM encodings and sizing helper for the serial comparator
package comparator_serial_bdeduffy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for sizing the digit index and the cycles counter
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/comparator_serial_bdeduffy_cmp_digit.sv
// rtl/comparator_serial_bdeduffy_cmp_digit.sv - combinational unsigned compare of one digit
module comparator_serial_bdeduffy_cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] digA,
    input  logic [DIGIT-1:0] digB,
    output logic             gt,
    output logic             lt
);

    // Plain magnitude compare; sign handling happens upstream by MSB inversion
    always_comb begin
        gt = (digA > digB);
        lt = (digA < digB);
    end

endmodule

// File: rtl/comparator_serial_bdeduffy.sv
// rtl/comparator_serial_bdeduffy.sv - MSB-first digit-serial magnitude comparator with six registered flags
module comparator_serial_bdeduffy
    import comparator_serial_bdeduffy_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              sgn,
    input  logic [WIDTH-1:0]                  valA,
    input  logic [WIDTH-1:0]                  valB,
    output logic                              busy,
    output logic                              done,
    output logic                              aGTb,
    output logic                              aGEb,
    output logic                              aLTb,
    output logic                              aLEb,
    output logic                              aEQb,
    output logic                              aNEb,
    output logic [clog2(WIDTH/DIGIT):0]       cycles
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = clog2(N) + 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state;
    state_t            nextState;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic              gt;
    logic              lt;
    logic [IDXW-1:0]   idx;
    logic [DIGIT-1:0]  digA;
    logic [DIGIT-1:0]  digB;
    logic              digGt;
    logic              digLt;
    logic              newGt;
    logic              newLt;
    logic              lastDigit;
    logic              decided;

    // Digit mux: idx 0 selects the most-significant DIGIT bits
    always_comb begin
        digA = DIGIT'(opA >> (DIGIT * (N - 1 - int'(idx))));
        digB = DIGIT'(opB >> (DIGIT * (N - 1 - int'(idx))));
    end

    comparator_serial_bdeduffy_cmp_digit #(
        .DIGIT (DIGIT)
    ) uCmpDigit (
        .digA (digA),
        .digB (digB),
        .gt   (digGt),
        .lt   (digLt)
    );

    // First unequal digit wins; later digits never overwrite the verdict
    always_comb begin
        newGt     = gt | (~gt & ~lt & digGt);
        newLt     = lt | (~gt & ~lt & digLt);
        lastDigit = (idx == IDXW'(N - 1));
        decided   = lastDigit | ((EARLY_EXIT != 0) & (newGt | newLt));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CMP;
            CMP:     if (decided) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand latch, digit walk and flag registration on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            opA    <= '0;
            opB    <= '0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            idx    <= '0;
            cycles <= '0;
            aGTb   <= 1'b0;
            aGEb   <= 1'b0;
            aLTb   <= 1'b0;
            aLEb   <= 1'b0;
            aEQb   <= 1'b0;
            aNEb   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA <= sgn ? (valA ^ MSB_MASK) : valA;
                        opB <= sgn ? (valB ^ MSB_MASK) : valB;
                        gt  <= 1'b0;
                        lt  <= 1'b0;
                        idx <= '0;
                    end
                end
                CMP: begin
                    gt <= newGt;
                    lt <= newLt;
                    if (decided) begin
                        cycles <= idx + 1'b1;
                        aGTb   <= newGt;
                        aLTb   <= newLt;
                        aEQb   <= ~newGt & ~newLt;
                        aNEb   <= newGt | newLt;
                        aGEb   <= ~newLt;
                        aLEb   <= ~newGt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_comparator_serial_bdeduffy.sv
// tb/tb_comparator_serial_bdeduffy.sv - table-driven bench for the serial comparator, early-exit and full-scan instances
module tb_comparator_serial_bdeduffy;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start0;
    logic       sgn;
    logic [7:0] valA;
    logic [7:0] valB;

    logic       busy1, done1, gt1, ge1, lt1, le1, eq1, ne1;
    logic       busy0, done0, gt0, ge0, lt0, le0, eq0, ne0;
    logic [2:0] cycles1;
    logic [2:0] cycles0;

    int errors;
    int checks;

    comparator_serial_bdeduffy #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dutEarly (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn), .valA(valA), .valB(valB),
        .busy(busy1), .done(done1), .aGTb(gt1), .aGEb(ge1), .aLTb(lt1), .aLEb(le1),
        .aEQb(eq1), .aNEb(ne1), .cycles(cycles1)
    );

    comparator_serial_bdeduffy #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dutFull (
        .clk(clk), .rst(rst), .start(start0), .sgn(sgn), .valA(valA), .valB(valB),
        .busy(busy0), .done(done0), .aGTb(gt0), .aGEb(ge0), .aLTb(lt0), .aLEb(le0),
        .aEQb(eq0), .aNEb(ne0), .cycles(cycles0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag order: {GT, GE, LT, LE, EQ, NE}
    localparam logic [5:0] F_GT = 6'b110001;
    localparam logic [5:0] F_LT = 6'b001101;
    localparam logic [5:0] F_EQ = 6'b010110;

    typedef struct {
        logic       ee;
        logic       sg;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] expFlags;
        int         expCycles;
        int         expLat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] flagsOf(input logic ee);
        if (ee) return {gt1, ge1, lt1, le1, eq1, ne1};
        return {gt0, ge0, lt0, le0, eq0, ne0};
    endfunction

    function automatic logic doneOf(input logic ee);
        return ee ? done1 : done0;
    endfunction

    function automatic int cyclesOf(input logic ee);
        return ee ? int'(cycles1) : int'(cycles0);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Accept a start on the chosen instance; lat = edges from the accept edge to the first edge after which done is high
    task automatic runOp(input logic ee, input logic sg, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        sgn  = sg;
        valA = a;
        valB = b;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start0 = 1'b0;
        lat = 0;
        while (!doneOf(ee) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    int doneCount;
    int lastDone;
    int gapBad;
    int sawDone;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        sgn    = 1'b0;
        valA   = 8'h00;
        valB   = 8'h00;

        vecs[0]  = '{1'b1, 1'b0, 8'hA5, 8'h5A, F_GT, 1, 1};
        vecs[1]  = '{1'b1, 1'b0, 8'h3C, 8'h3C, F_EQ, 4, 4};
        vecs[2]  = '{1'b1, 1'b1, 8'h80, 8'h01, F_LT, 1, 1};
        vecs[3]  = '{1'b1, 1'b0, 8'h80, 8'h01, F_GT, 1, 1};
        vecs[4]  = '{1'b0, 1'b0, 8'hC0, 8'h00, F_GT, 4, 4};
        vecs[5]  = '{1'b1, 1'b0, 8'h01, 8'h02, F_LT, 4, 4};
        vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h02, F_LT, 4, 4};
        vecs[7]  = '{1'b0, 1'b1, 8'h80, 8'h01, F_LT, 4, 4};
        vecs[8]  = '{1'b1, 1'b1, 8'hFF, 8'h01, F_LT, 1, 1};
        vecs[9]  = '{1'b1, 1'b0, 8'h20, 8'h10, F_GT, 2, 2};
        vecs[10] = '{1'b1, 1'b1, 8'h7F, 8'h80, F_GT, 1, 1};
        vecs[11] = '{1'b0, 1'b0, 8'h3C, 8'h3C, F_EQ, 4, 4};

        // Reset state, with start asserted to show rst wins
        @(negedge clk);
        start1 = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        check("reset_busy_early", busy1, 0);
        check("reset_busy_full", busy0, 0);
        check("reset_done", {done1, done0}, 0);
        check("reset_flags_early", flagsOf(1'b1), 0);
        check("reset_flags_full", flagsOf(1'b0), 0);
        check("reset_cycles", {cycles1, cycles0}, 0);
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
        rst    = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].ee, vecs[i].sg, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
            check($sformatf("vec%0d_flags", i), flagsOf(vecs[i].ee), vecs[i].expFlags);
            check($sformatf("vec%0d_cycles", i), cyclesOf(vecs[i].ee), vecs[i].expCycles);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), doneOf(vecs[i].ee), 0);
            check($sformatf("vec%0d_flags_hold", i), flagsOf(vecs[i].ee), vecs[i].expFlags);
        end

        // start held high: one done per accept, accepts three edges apart
        @(negedge clk);
        sgn    = 1'b0;
        valA   = 8'hA5;
        valB   = 8'h5A;
        start1 = 1'b1;
        doneCount = 0;
        lastDone  = -1;
        gapBad    = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                doneCount++;
                if (lastDone >= 0 && (e - lastDone) != 3) gapBad++;
                lastDone = e;
            end
        end
        @(negedge clk);
        start1 = 1'b0;
        check("held_start_done_count", doneCount, 4);
        check("held_start_spacing", gapBad, 0);
        repeat (3) @(posedge clk);

        // Reset during the second CMP cycle abandons the operation
        @(negedge clk);
        valA   = 8'h3C;
        valB   = 8'h3C;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_still_busy", busy1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy1, 0);
        check("midrst_flags", flagsOf(1'b1), 0);
        check("midrst_cycles", cycles1, 0);
        sawDone = 0;
        for (int e = 0; e < 6; e++) begin
            if (done1) sawDone++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", sawDone, 0);

        runOp(1'b1, 1'b0, 8'h10, 8'h20, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_flags", flagsOf(1'b1), F_LT);
        check("post_rst_cycles", cycles1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
